// File: rtl/pll_rst_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// Purely declarative: no logic, no latency, no backpressure.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        FILTER,
        REL_PERIPH,
        RUN,
        SOFT_RST
    } state_e;

    localparam int LOSS_CNT_W = 8;

    // One extra bit beyond clog2 so every terminal count fits comfortably.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit N-flop synchronizer with async active-low reset; latency STAGES clocks.
// No backpressure: samples d_i on every clock edge.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Filters PLL lock and releases peripheral then core resets; periph after SYNC+FILTER edges, core CORE_DELAY later.
// No backpressure: lock loss or soft request re-asserts resets on the next edge, all outputs registered.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_FILTER_CYCLES = 1024,
    parameter int CORE_DELAY_CYCLES  = 16,
    parameter int SOFT_RST_CYCLES    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic                  periph_rst_n,
    output logic                  core_rst_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CW = cnt_width(LOCK_FILTER_CYCLES, CORE_DELAY_CYCLES, SOFT_RST_CYCLES);
    localparam logic [CW-1:0] FILTER_LAST = CW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CW-1:0] CORE_LAST   = CW'(CORE_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_RST_CYCLES - 1);

    if (SYNC_STAGES < 2 || LOCK_FILTER_CYCLES < 1 ||
        CORE_DELAY_CYCLES < 1 || SOFT_RST_CYCLES < 1) begin : g_bad_params
        $fatal(1, "pll_reset_sequencer: parameter out of range");
    end

    logic                  locked_s;
    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  periph_q;
    logic                  core_q;
    logic                  ready_q;
    logic [LOSS_CNT_W-1:0] loss_q;
    logic [LOSS_CNT_W-1:0] loss_d;
    logic                  lost;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    // Lock loss only counts once resets have been released at least partially.
    assign lost = !locked_s && (state_q == REL_PERIPH || state_q == RUN || state_q == SOFT_RST);

    always_comb begin
        loss_d = (loss_q == '1) ? loss_q : loss_q + LOSS_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            ready_q  <= 1'b0;
            loss_q   <= '0;
        end else if (lost) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            ready_q  <= 1'b0;
            loss_q   <= loss_d;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= FILTER;
                        cnt_q   <= '0;
                    end
                end
                FILTER: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == FILTER_LAST) begin
                        state_q  <= REL_PERIPH;
                        cnt_q    <= '0;
                        periph_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                REL_PERIPH: begin
                    if (cnt_q == CORE_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        core_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (soft_rst_req) begin
                        state_q  <= SOFT_RST;
                        cnt_q    <= '0;
                        periph_q <= 1'b0;
                        core_q   <= 1'b0;
                        ready_q  <= 1'b0;
                    end
                end
                SOFT_RST: begin
                    if (soft_rst_req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == SOFT_LAST) begin
                        state_q  <= REL_PERIPH;
                        cnt_q    <= '0;
                        periph_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= WAIT_LOCK;
                    cnt_q    <= '0;
                    periph_q <= 1'b0;
                    core_q   <= 1'b0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign periph_rst_n  = periph_q;
    assign core_rst_n    = core_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system PLL and is clocked by the PLL's 25 MHz output clock.
- Consumes the PLL lock indication and filters it.
- Produces staged, synchronously-deasserted active-low resets: peripherals/memory are released first, then the RISC-V core.
- Handles loss of lock and software reset requests, and keeps a saturating lock-loss counter for diagnostics.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchronizer (>=2)
LOCK_FILTER_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=1)
CORE_DELAY_CYCLES, 16, cycles between periph_rst_n and core_rst_n deassertion (>=1)
SOFT_RST_CYCLES, 32, reset hold after soft_rst_req deasserts (>=1)

Ports:
clk  input  1  PLL output clock (25 MHz); sole clock
rst_n  input  1  asynchronous, active-low reset (board reset)
pll_locked  input  1  PLL lock flag; asynchronous to clk
soft_rst_req  input  1  software reset request from core domain (same clk), level
periph_rst_n  output  1  peripheral/memory reset, active-low
core_rst_n  output  1  RISC-V core reset, active-low
ready  output  1  high when sequence complete (RUN state)
lock_loss_cnt  output  8  saturating count of lock losses after release

Behaviour:
- All flops, including the synchronizer, are async-reset by rst_n low. Reset values: periph_rst_n=0, core_rst_n=0, ready=0, lock_loss_cnt=0, sync chain=0, state=WAIT_LOCK, cnt=0.
- rst_n asserted mid-operation: immediate return to reset values. Deassertion of rst_n restarts from WAIT_LOCK.
- pll_locked passes through a SYNC_STAGES flop chain, giving locked_s. The FSM uses only locked_s.
- All outputs are registered; no combinational paths from inputs to outputs.
- One shared counter cnt, width clog2(max(LOCK_FILTER_CYCLES, CORE_DELAY_CYCLES, SOFT_RST_CYCLES))+1, cleared on every state entry.
- WAIT_LOCK: periph_rst_n=0, core_rst_n=0, ready=0. locked_s=1 -> FILTER.
- FILTER:
  - locked_s=0 -> WAIT_LOCK; no loss count (acquisition glitch).
  - Otherwise cnt++. At cnt==LOCK_FILTER_CYCLES-1 -> REL_PERIPH; periph_rst_n=1 registered on that edge.
- REL_PERIPH: periph_rst_n=1, core_rst_n=0. cnt++; at cnt==CORE_DELAY_CYCLES-1 -> RUN; core_rst_n=1 and ready=1 on that edge.
- RUN: all released. soft_rst_req=1 -> SOFT_RST; core_rst_n=0, periph_rst_n=0, ready=0 on that edge.
- SOFT_RST:
  - While soft_rst_req=1, cnt is held at 0.
  - Once it is low, cnt++. At cnt==SOFT_RST_CYCLES-1 -> REL_PERIPH (the lock filter is skipped).
- Lock loss (locked_s=0 in REL_PERIPH, RUN or SOFT_RST):
  - Next state is WAIT_LOCK; all resets asserted and ready=0 on that edge.
  - lock_loss_cnt increments, saturating at 255.
  - Lock loss has priority over soft_rst_req and over counter terminal events in the same cycle.
- lock_loss_cnt is cleared only by rst_n.
- Latency from pll_locked rising (sample edge = 0):
  - periph_rst_n high after edge SYNC_STAGES+LOCK_FILTER_CYCLES.
  - core_rst_n/ready high CORE_DELAY_CYCLES edges later.
- Latency from pll_locked falling (sample edge = 0): resets asserted after edge SYNC_STAGES.
- Out-of-range parameters are a fatal elaboration error (generate-time check).

Decomposition:
- Shared package pll_rst_pkg holds:
  - the state enum typedef (WAIT_LOCK, FILTER, REL_PERIPH, RUN, SOFT_RST);
  - the lock_loss_cnt width constant (8);
  - a clog2-based counter-width function.
- One sub-module: sync_bit, a parameterized SYNC_STAGES flop chain with async active-low reset, reusable for other CDC bits.
- FSM and counter stay in the top module.

Test Plan:
(Parameters for all scenarios: SYNC_STAGES=2, LOCK_FILTER_CYCLES=8, CORE_DELAY_CYCLES=4, SOFT_RST_CYCLES=5.)
1. Power-up: rst_n low 3 cycles then high; pll_locked rises, first sampled at edge 0 -> periph_rst_n=1 after edge 10; core_rst_n=1, ready=1 after edge 14; lock_loss_cnt=0.
2. Lock glitch during FILTER: pll_locked low for 1 cycle at edge 6 -> no release before edge 6+2+2+8; lock_loss_cnt stays 0.
3. Lock loss in RUN: pll_locked falls, sampled at edge 0 -> periph_rst_n=0, core_rst_n=0, ready=0 after edge 2; lock_loss_cnt=1; relock repeats the 10/14-edge sequence.
4. Soft reset: soft_rst_req high 3 cycles in RUN -> resets low the edge after first sample; after req low, 5 cycles hold, then periph_rst_n=1, then core_rst_n=1 4 edges later; no filter delay.
5. Priority: pll_locked drop and soft_rst_req in the same cycle -> WAIT_LOCK, lock_loss_cnt increments; 300 forced losses -> lock_loss_cnt saturates at 255.
6. rst_n pulled low during REL_PERIPH -> all outputs 0 immediately (asynchronous), lock_loss_cnt=0; restart from WAIT_LOCK.
